// File: rtl/hitmem_fill.sv
// Write side of the per-layer hit memory: stores one event's hits from address 0,
// then holds the hit count for the reader until it releases the event.
module hitmem_fill #(
    parameter int DATA_W   = 21,
    parameter int ADDR_W   = 5,
    parameter int MAX_HITS = 31
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_ee,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              evt_valid,
    output logic [ADDR_W-1:0] nhits,
    output logic              evt_empty,
    output logic              overflow,
    input  logic              rd_done
);

    localparam logic [ADDR_W-1:0] CNT_MAX = ADDR_W'(MAX_HITS);

    typedef enum logic {
        S_FILL = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] count_q, count_d;
    logic [ADDR_W-1:0] nhits_q, nhits_d;
    logic              empty_q, empty_d;
    logic              ovf_q, ovf_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic accept, hit_acc, ee_acc, hit_wr, hit_ovf, release_evt;

    assign accept      = in_valid & (state_q == S_FILL);
    assign hit_acc     = accept & ~in_ee;
    assign ee_acc      = accept & in_ee;
    assign hit_wr      = hit_acc & (count_q != CNT_MAX);
    assign hit_ovf     = hit_acc & (count_q == CNT_MAX);
    assign release_evt = (state_q == S_HOLD) & rd_done;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FILL:  if (ee_acc) state_d = S_HOLD;
            S_HOLD:  if (rd_done) state_d = S_FILL;
            default: state_d = S_FILL;
        endcase
    end

    // Hits beyond CNT_MAX are dropped; the count saturates so nhits never wraps.
    always_comb begin
        count_d   = count_q;
        nhits_d   = nhits_q;
        empty_d   = empty_q;
        ovf_d     = ovf_q;
        wr_en_d   = hit_wr;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (hit_wr) begin
            count_d   = count_q + ADDR_W'(1);
            wr_addr_d = count_q;
            wr_data_d = in_data;
        end
        if (hit_ovf) begin
            ovf_d = 1'b1;
        end
        if (ee_acc) begin
            nhits_d = count_q;
            empty_d = (count_q == '0);
        end
        if (release_evt) begin
            count_d = '0;
            nhits_d = '0;
            empty_d = 1'b0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q   <= '0;
            nhits_q   <= '0;
            empty_q   <= 1'b0;
            ovf_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            count_q   <= count_d;
            nhits_q   <= nhits_d;
            empty_q   <= empty_d;
            ovf_q     <= ovf_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_comb begin
        in_ready  = (state_q == S_FILL);
        evt_valid = (state_q == S_HOLD);
        wr_en     = wr_en_q;
        wr_addr   = wr_addr_q;
        wr_data   = wr_data_q;
        nhits     = nhits_q;
        evt_empty = empty_q;
        overflow  = ovf_q;
    end

endmodule

// File: tb/tb_hitmem_fill.sv
// Directed and randomised-gap bench for hitmem_fill: checks write strobes, addresses,
// data and the held event summary against hand-computed expectations.
module tb_hitmem_fill;

    localparam int DATA_W   = 21;
    localparam int ADDR_W   = 5;
    localparam int MAX_HITS = 31;

    logic              clock = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ee;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              evt_valid;
    logic [ADDR_W-1:0] nhits;
    logic              evt_empty;
    logic              overflow;
    logic              rd_done;

    int n_checks = 0;
    int n_errors = 0;

    int                wq_addr[$];
    logic [DATA_W-1:0] wq_data[$];
    logic [DATA_W-1:0] sent[$];

    hitmem_fill #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_HITS(MAX_HITS)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ee    (in_ee),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .evt_valid(evt_valid),
        .nhits    (nhits),
        .evt_empty(evt_empty),
        .overflow (overflow),
        .rd_done  (rd_done)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (wr_en === 1'b1) begin
            wq_addr.push_back(int'(wr_addr));
            wq_data.push_back(wr_data);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the word is accepted, in_valid still high.
    task automatic send_word(input logic [DATA_W-1:0] d, input logic ee);
        int waited = 0;
        in_data  = d;
        in_ee    = ee;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && waited < 100) begin
            @(negedge clock);
            waited++;
        end
        if (in_ready !== 1'b1) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
        end else begin
            @(negedge clock);
        end
    endtask

    task automatic idle(input int cycles);
        in_valid = 1'b0;
        in_ee    = 1'b0;
        repeat (cycles) @(negedge clock);
    endtask

    task automatic new_event();
        wq_addr.delete();
        wq_data.delete();
        sent.delete();
    endtask

    task automatic check_event(input string tag);
        int exp_n;
        exp_n = (sent.size() > MAX_HITS) ? MAX_HITS : sent.size();
        check({tag, "_evt_valid"}, 32'(evt_valid), 32'd1);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_nwrites"}, 32'(wq_addr.size()), 32'(exp_n));
        check({tag, "_nhits"}, 32'(nhits), 32'(exp_n));
        check({tag, "_empty"}, 32'(evt_empty), 32'(sent.size() == 0));
        check({tag, "_overflow"}, 32'(overflow), 32'(sent.size() > MAX_HITS));
        for (int i = 0; i < wq_addr.size() && i < exp_n; i++) begin
            if (wq_addr[i] != i || wq_data[i] !== sent[i]) begin
                check({tag, "_wr_addr"}, 32'(wq_addr[i]), 32'(i));
                check({tag, "_wr_data"}, 32'(wq_data[i]), 32'(sent[i]));
            end
        end
    endtask

    task automatic release_evt(input int hold_cycles);
        in_valid = 1'b1;
        in_ee    = 1'b0;
        in_data  = 21'h1ABCD;
        repeat (hold_cycles) @(negedge clock);
        in_valid = 1'b0;
        rd_done  = 1'b1;
        @(negedge clock);
        rd_done = 1'b0;
        check("rel_evt_valid", 32'(evt_valid), 32'd0);
        check("rel_in_ready", 32'(in_ready), 32'd1);
        check("rel_nhits", 32'(nhits), 32'd0);
        check("rel_overflow", 32'(overflow), 32'd0);
        check("rel_empty", 32'(evt_empty), 32'd0);
    endtask

    initial begin
        logic [DATA_W-1:0] d;
        int nh;
        logic [ADDR_W-1:0] held_n;
        int wr_before;

        reset    = 1'b1;
        in_data  = '0;
        in_valid = 1'b0;
        in_ee    = 1'b0;
        rd_done  = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_evt_valid", 32'(evt_valid), 32'd0);
        check("rst_nhits", 32'(nhits), 32'd0);
        check("rst_empty", 32'(evt_empty), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Three hits A,B,C then EE, one-cycle write latency on each
        new_event();
        sent.push_back(21'h0A0A1);
        sent.push_back(21'h0B0B2);
        sent.push_back(21'h1C0C3);
        for (int i = 0; i < 3; i++) begin
            check("t1_wr_idle", 32'(wr_en), 32'(i != 0));
            send_word(sent[i], 1'b0);
            check("t1_wr_en", 32'(wr_en), 32'd1);
            check("t1_wr_addr", 32'(wr_addr), 32'(i));
            check("t1_wr_data", 32'(wr_data), 32'(sent[i]));
        end
        send_word(21'h1FFFF, 1'b1);
        check("t1_ee_no_write", 32'(wr_en), 32'd0);
        in_valid = 1'b0;
        check_event("t1");
        release_evt(0);

        // EE only
        new_event();
        send_word(21'h12345, 1'b1);
        in_valid = 1'b0;
        check("t2_no_write", 32'(wr_en), 32'd0);
        check_event("t2");
        release_evt(1);

        // 33 hits then EE: saturate at 31
        new_event();
        for (int i = 0; i < 33; i++) begin
            d = DATA_W'(21'h10000 + i * 3);
            sent.push_back(d);
            check("t3_in_ready", 32'(in_ready), 32'd1);
            send_word(d, 1'b0);
        end
        check("t3_ovf_before_ee", 32'(overflow), 32'd1);
        send_word('0, 1'b1);
        in_valid = 1'b0;
        check_event("t3");

        // Held event ignores input traffic
        held_n    = nhits;
        wr_before = wq_addr.size();
        in_valid  = 1'b1;
        in_ee     = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_data = DATA_W'(21'h00F00 + i);
            @(negedge clock);
            check("t4_in_ready", 32'(in_ready), 32'd0);
            check("t4_wr_en", 32'(wr_en), 32'd0);
        end
        check("t4_nhits", 32'(nhits), 32'(held_n));
        check("t4_no_writes", 32'(wq_addr.size()), 32'(wr_before));
        release_evt(0);
        new_event();
        sent.push_back(21'h05555);
        send_word(sent[0], 1'b0);
        check("t4_next_addr", 32'(wr_addr), 32'd0);
        check("t4_next_wr_en", 32'(wr_en), 32'd1);
        send_word('0, 1'b1);
        in_valid = 1'b0;
        check_event("t4");
        release_evt(2);

        // Reset mid-event
        new_event();
        for (int i = 0; i < 5; i++) begin
            send_word(DATA_W'(21'h0AA00 + i), 1'b0);
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clock);
        check("t5_rst_wr_en", 32'(wr_en), 32'd0);
        check("t5_rst_ready", 32'(in_ready), 32'd1);
        reset = 1'b0;
        new_event();
        idle(3);
        check("t5_no_writes", 32'(wq_addr.size()), 32'd0);
        sent.push_back(21'h13579);
        sent.push_back(21'h02468);
        send_word(sent[0], 1'b0);
        send_word(sent[1], 1'b0);
        send_word('0, 1'b1);
        in_valid = 1'b0;
        check_event("t5");
        release_evt(1);

        // Twenty events with random gaps and random hold times
        for (int e = 0; e < 20; e++) begin
            new_event();
            nh = (e == 0) ? 31 : (e == 1) ? 32 : (e == 2) ? 0 : int'($urandom_range(0, 40));
            for (int i = 0; i < nh; i++) begin
                d = DATA_W'($urandom);
                sent.push_back(d);
                if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
                send_word(d, 1'b0);
            end
            if ($urandom_range(0, 1) == 0) idle(1);
            send_word('0, 1'b1);
            in_valid = 1'b0;
            check_event("t6");
            release_evt(int'($urandom_range(0, 4)));
        end

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
